// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and atan table for the CORDIC rotator
//   GUARD_BITS                    : extra MSBs carried through the datapath
//   quarter_turn/three_quarter_turn: +90 / -90 degree phase steps (0x4000 / 0xC000 at 16 bits)
//   atan_angle(i, zwidth)         : round(atan(2^-i) * 2^zwidth / 2pi)
package cordic_pkg;
  localparam int GUARD_BITS = 2;
  // atan(2^-i) scaled to a 2^32 full circle; narrowed with rounding below
  localparam logic [31:0] ATAN32 [16] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861
  };
  function automatic logic [31:0] atan_angle(input int i, input int zwidth);
    return (ATAN32[i] + (32'd1 << (31 - zwidth))) >> (32 - zwidth);
  endfunction
  function automatic logic [31:0] quarter_turn(input int zwidth);
    return 32'd1 << (zwidth - 2);
  endfunction
  function automatic logic [31:0] three_quarter_turn(input int zwidth);
    return 32'd3 << (zwidth - 2);
  endfunction
endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered CORDIC micro-rotation by +/-atan(2^-SHIFT)
//   clock, reset (sync, active-high), enable (hold when low)
//   xi/yi/zi : previous-stage vector and residual phase
//   xo/yo/zo : rotated vector and updated residual phase
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int IW = 18,
  parameter int ZWIDTH = 16,
  parameter int SHIFT = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [IW-1:0]     xi,
  input  logic signed [IW-1:0]     yi,
  input  logic        [ZWIDTH-1:0] zi,
  output logic signed [IW-1:0]     xo,
  output logic signed [IW-1:0]     yo,
  output logic        [ZWIDTH-1:0] zo
);
  localparam logic [ZWIDTH-1:0] ANGLE = ZWIDTH'(atan_angle(SHIFT, ZWIDTH));
  // negative residual phase rotates clockwise, otherwise counter-clockwise
  always_ff @(posedge clock)
    if (reset) begin
      xo <= '0;
      yo <= '0;
      zo <= '0;
    end else if (enable) begin
      xo <= zi[ZWIDTH-1] ? xi + (yi >>> SHIFT) : xi - (yi >>> SHIFT);
      yo <= zi[ZWIDTH-1] ? yi - (xi >>> SHIFT) : yi + (xi >>> SHIFT);
      zo <= zi[ZWIDTH-1] ? zi + ANGLE : zi - ANGLE;
    end
endmodule

// File: rtl/cordic_rotator.sv
// cordic_rotator: pipelined CORDIC rotator, (xo,yo) = 0.8234 * rot(zi) * (xi,yi)
//   clock, reset (sync, active-high, clears the pipeline), enable (advance)
//   xi/yi : signed input vector      zi : rotation phase, 2^ZWIDTH = full circle
//   xo/yo : rotated vector           zo : residual phase (debug)
//   latency STAGES+1 enabled edges, one sample per enabled cycle
//   CORDIC_PHASE_OFFSET_REG_EN: adds a settings-bus phase-offset register at
//   OFFSET_ADDR (serial_addr/serial_data/serial_strobe) added to zi
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ZWIDTH = 16,
  parameter int STAGES = 12
`ifdef CORDIC_PHASE_OFFSET_REG_EN
  ,
  parameter int OFFSET_ADDR = 0
`endif
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [WIDTH-1:0]  xi,
  input  logic signed [WIDTH-1:0]  yi,
  input  logic        [ZWIDTH-1:0] zi,
  output logic signed [WIDTH-1:0]  xo,
  output logic signed [WIDTH-1:0]  yo,
  output logic        [ZWIDTH-1:0] zo
`ifdef CORDIC_PHASE_OFFSET_REG_EN
  ,
  input  logic        [6:0]        serial_addr,
  input  logic        [31:0]       serial_data,
  input  logic                     serial_strobe
`endif
);
  localparam int IW = WIDTH + GUARD_BITS;
  localparam logic [ZWIDTH-1:0] Q_P = ZWIDTH'(quarter_turn(ZWIDTH));
  localparam logic [ZWIDTH-1:0] Q_M = ZWIDTH'(three_quarter_turn(ZWIDTH));
  logic        [ZWIDTH-1:0] z_adj;
  logic signed [IW-1:0]     x_ext, y_ext, x0, y0;
  logic        [ZWIDTH-1:0] z0;
  logic        [1:0]        quad;
  logic signed [IW-1:0]     xs [STAGES+1];
  logic signed [IW-1:0]     ys [STAGES+1];
  logic        [ZWIDTH-1:0] zs [STAGES+1];
  logic                     unused_guard;
`ifdef CORDIC_PHASE_OFFSET_REG_EN
  // power-up value only; deliberately survives reset
  logic [ZWIDTH-1:0] phase_offset = '0;
  logic              unused_serial;
  always_ff @(posedge clock)
    if (serial_strobe && serial_addr == 7'(OFFSET_ADDR))
      phase_offset <= serial_data[31:32-ZWIDTH];
  assign unused_serial = ^serial_data[31-ZWIDTH:0];
  assign z_adj = zi + phase_offset;
`else
  assign z_adj = zi;
`endif
  assign x_ext = {{GUARD_BITS{xi[WIDTH-1]}}, xi};
  assign y_ext = {{GUARD_BITS{yi[WIDTH-1]}}, yi};
  assign quad  = z_adj[ZWIDTH-1:ZWIDTH-2];
  // coarse +/-90 degree pre-rotation brings the phase into +/-90 where the stages converge
  always_ff @(posedge clock)
    if (reset) begin
      x0 <= '0;
      y0 <= '0;
      z0 <= '0;
    end else if (enable) begin
      x0 <= quad == 2'b01 ? -y_ext : quad == 2'b10 ? y_ext : x_ext;
      y0 <= quad == 2'b01 ? x_ext : quad == 2'b10 ? -x_ext : y_ext;
      z0 <= quad == 2'b01 ? z_adj + Q_M : quad == 2'b10 ? z_adj + Q_P : z_adj;
    end
  assign xs[0] = x0;
  assign ys[0] = y0;
  assign zs[0] = z0;
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_stage #(.IW(IW), .ZWIDTH(ZWIDTH), .SHIFT(i)) u_stage (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .xi     (xs[i]),
      .yi     (ys[i]),
      .zi     (zs[i]),
      .xo     (xs[i+1]),
      .yo     (ys[i+1]),
      .zo     (zs[i+1])
    );
  end
  // drop the top guard bit and the LSB: halves the CORDIC gain
  assign xo = xs[STAGES][WIDTH:1];
  assign yo = ys[STAGES][WIDTH:1];
  assign zo = zs[STAGES];
  assign unused_guard = ^{xs[STAGES][IW-1], xs[STAGES][0], ys[STAGES][IW-1], ys[STAGES][0]};
endmodule

// File: tb/tb_cordic_rotator.sv
// tb_cordic_rotator: scoreboard bench for cordic_rotator
module tb_cordic_rotator;
  localparam int LAT = 13;
  // residual phase after 12 stages can reach ~5 phase LSB (~6 output LSB at
  // this amplitude) plus truncation, so the nominal-value checks use a wider band
  localparam int TOL = 10;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic signed [15:0] xi = '0, yi = '0, xo, yo;
  logic [15:0] zi = '0, zo;
`ifdef CORDIC_PHASE_OFFSET_REG_EN
  logic [6:0]  serial_addr = '0;
  logic [31:0] serial_data = '0;
  logic        serial_strobe = 1'b0;
`endif
  int checks = 0, failures = 0, en_cnt = 0, offset = 0;
  int atab [12];
  typedef struct {
    int x; int y; int z; int sx; int sy; int stamp; bit spec;
  } exp_t;
  exp_t sb [$];

  always #5 clock = ~clock;

  cordic_rotator dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .xi     (xi),
    .yi     (yi),
    .zi     (zi),
    .xo     (xo),
    .yo     (yo),
    .zo     (zo)
`ifdef CORDIC_PHASE_OFFSET_REG_EN
    ,
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    checks++;
    assert ((obs >= exp - TOL && obs <= exp + TOL) === 1'b1) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d+-%0d", tag, obs, exp, TOL);
    end
  endtask

  // reference rotation straight from the algorithm description, angle table from $atan
  function automatic void model(input int xin, input int yin, input int zin,
                                output int xr, output int yr, output int zr);
    int x, y, z, t;
    logic signed [15:0] h;
    x = xin;
    y = yin;
    z = zin & 'hFFFF;
    if ((z >> 14) == 1) begin
      x = -yin; y = xin; z = (z - 'h4000) & 'hFFFF;
    end else if ((z >> 14) == 2) begin
      x = yin; y = -xin; z = (z + 'h4000) & 'hFFFF;
    end
    for (int i = 0; i < 12; i++) begin
      if ((z & 'h8000) != 0) begin
        t = x + (y >>> i); y = y - (x >>> i); x = t; z = (z + atab[i]) & 'hFFFF;
      end else begin
        t = x - (y >>> i); y = y + (x >>> i); x = t; z = (z - atab[i]) & 'hFFFF;
      end
    end
    h = 16'(x >>> 1);
    xr = h;
    h = 16'(y >>> 1);
    yr = h;
    zr = z;
  endfunction

  task automatic tick(input bit en, input bit push, input int x, input int y, input int z,
                      input bit spec, input int sx, input int sy);
    exp_t e;
    int ex, ey, ez;
    enable = en;
    xi = 16'(x);
    yi = 16'(y);
    zi = 16'(z);
    if (en && push) begin
      model(x, y, z + offset, ex, ey, ez);
      e.x = ex; e.y = ey; e.z = ez; e.sx = sx; e.sy = sy; e.spec = spec; e.stamp = en_cnt;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    if (en) en_cnt++;
    if (sb.size() > 0 && en_cnt - sb[0].stamp == LAT) begin
      e = sb.pop_front();
      chk("xo", int'(xo), e.x);
      chk("yo", int'(yo), e.y);
      chk("zo", int'(zo), e.z);
      if (e.spec) begin
        chk_near("xo_nominal", int'(xo), e.sx);
        chk_near("yo_nominal", int'(yo), e.sy);
      end
    end
  endtask

  task automatic do_reset(input bit en);
    reset = 1'b1;
    enable = en;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_xo", int'(xo), 0);
    chk("reset_yo", int'(yo), 0);
    chk("reset_zo", int'(zo), 0);
    sb.delete();
  endtask

  task automatic flush();
    int n = 0;
    while (sb.size() > 0 && n < 3 * LAT) begin
      tick(1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 0);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int k, n;
    for (int i = 0; i < 12; i++)
      atab[i] = int'($atan(2.0 ** (-i)) * 65536.0 / (2.0 * 3.14159265358979));
    do_reset(1'b0);
    tick(1'b1, 1'b1, 16000, 0, 'h0000, 1'b1, 13174, 0);
    tick(1'b1, 1'b1, 16000, 0, 'h4000, 1'b1, 0, 13174);
    tick(1'b1, 1'b1, 16000, 0, 'h8000, 1'b1, -13174, 0);
    tick(1'b1, 1'b1, 16000, 0, 'h2000, 1'b1, 9315, 9315);
    tick(1'b1, 1'b1, 16000, 0, 'hE000, 1'b1, 9315, -9315);
    tick(1'b1, 1'b1, -32768, 32767, 'h6000, 1'b0, 0, 0);
    tick(1'b1, 1'b1, 32767, 32767, 'hA000, 1'b0, 0, 0);
    tick(1'b1, 1'b1, -32768, -32768, 'hFFFF, 1'b0, 0, 0);
    flush();
    k = 0;
    n = 0;
    while (n < 20) begin
      if (((k / 3) % 2) == 0) begin
        tick(1'b1, 1'b1, -15000 + n * 1500, 12000 - n * 1100, n * 3449, 1'b0, 0, 0);
        n++;
      end else
        tick(1'b0, 1'b0, int'($urandom), int'($urandom), int'($urandom), 1'b0, 0, 0);
      k++;
    end
    flush();
    for (int i = 0; i < 5; i++)
      tick(1'b1, 1'b1, 20000 - i * 3000, 7000 + i * 500, 'h1234 + i * 'h2000, 1'b0, 0, 0);
    do_reset(1'b1);
    tick(1'b1, 1'b1, 12345, -5432, 'h9ABC, 1'b0, 0, 0);
    for (int i = 0; i < LAT - 2; i++) begin
      tick(1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 0);
      chk("post_reset_xo", int'(xo), 0);
    end
    flush();
`ifdef CORDIC_PHASE_OFFSET_REG_EN
    serial_strobe = 1'b1;
    serial_addr = 7'd5;
    serial_data = 32'h8000_0000;
    tick(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
    serial_strobe = 1'b0;
    tick(1'b1, 1'b1, 16000, 0, 0, 1'b1, 13174, 0);
    flush();
    serial_strobe = 1'b1;
    serial_addr = 7'd0;
    serial_data = 32'h4000_0000;
    tick(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
    serial_strobe = 1'b0;
    offset = 'h4000;
    tick(1'b1, 1'b1, 16000, 0, 0, 1'b1, 0, 13174);
    flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
